// File: rtl/parking_management_if.sv
// ---------------------------------------------------------------------------
// parking_management_if
// Bundles the gate requests, the hour of day and the occupancy/vacancy
// reporting of the car park tracker.
//   master : gate/display side; drives the requests and current_hour and reads
//            the reports.
//   slave  : the tracker; reads the requests and drives the reports.
// Signals:
//   car_entered / is_uni_car_entered : entry request and car class (1 = uni)
//   car_exited  / is_uni_car_exited  : exit request and car class (1 = uni)
//   current_hour [4:0]               : hour of day, 0..23
//   uni_parked_car, parked_car [9:0] : cars parked per section
//   uni_vacated_space, vacated_space : free spaces per section
//   uni_is_vacated_space, is_vacated_space : free-space flags
// ---------------------------------------------------------------------------
interface parking_management_if;
    logic       car_entered;
    logic       is_uni_car_entered;
    logic       car_exited;
    logic       is_uni_car_exited;
    logic [4:0] current_hour;
    logic [9:0] uni_parked_car;
    logic [9:0] parked_car;
    logic [9:0] vacated_space;
    logic [9:0] uni_vacated_space;
    logic       uni_is_vacated_space;
    logic       is_vacated_space;

    modport master (
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output current_hour,
        input  uni_parked_car, parked_car, vacated_space, uni_vacated_space,
        input  uni_is_vacated_space, is_vacated_space
    );

    modport slave (
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  current_hour,
        output uni_parked_car, parked_car, vacated_space, uni_vacated_space,
        output uni_is_vacated_space, is_vacated_space
    );
endinterface

// File: rtl/parking_management.sv
// ---------------------------------------------------------------------------
// parking_management
// Occupancy tracker for a car park split into a university section and a
// general section. The university capacity follows the hour of day; the
// general section gets whatever remains of TOTAL_CAPACITY.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears both counters
//   bus   : parking_management_if.slave (requests, hour, reports)
// The two counters are the only state; every report is combinational from
// the counters and current_hour.
// Optional feature (macro PARKING_UNI_OVERFLOW_EN): university cars that find
// the university section full spill into the general section, and a
// university exit with no university car parked is taken from the general
// count instead.
// ---------------------------------------------------------------------------
module parking_management #(
    parameter int unsigned TOTAL_CAPACITY     = 700,
    parameter int unsigned UNI_DAY_CAPACITY   = 500,
    parameter int unsigned UNI_NIGHT_CAPACITY = 200,
    parameter int unsigned UNI_STEP           = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_management_if.slave  bus
);

    // University capacity for a given hour; hours 24..31 fall to night.
    function automatic logic [9:0] uni_cap_f(input logic [4:0] hour);
        logic [9:0] cap_v;
        case (hour)
            5'd8, 5'd9, 5'd10, 5'd11, 5'd12:
                cap_v = 10'(UNI_DAY_CAPACITY);
            5'd13:   cap_v = 10'(UNI_DAY_CAPACITY - UNI_STEP * 32'd1);
            5'd14:   cap_v = 10'(UNI_DAY_CAPACITY - UNI_STEP * 32'd2);
            5'd15:   cap_v = 10'(UNI_DAY_CAPACITY - UNI_STEP * 32'd3);
            default: cap_v = 10'(UNI_NIGHT_CAPACITY);
        endcase
        return cap_v;
    endfunction

    // Free spaces, saturating at zero when capacity shrank below the count.
    function automatic logic [9:0] vacancy_f(input logic [9:0] cap,
                                             input logic [9:0] count);
        logic [9:0] vac_v;
        if (count < cap) begin
            vac_v = cap - count;
        end else begin
            vac_v = 10'd0;
        end
        return vac_v;
    endfunction

    // Apply one optional increment and one optional decrement together.
    function automatic logic [9:0] step_f(input logic [9:0] count,
                                          input logic inc,
                                          input logic dec);
        logic [9:0] next_v;
        case ({inc, dec})
            2'b10:   next_v = count + 10'd1;
            2'b01:   next_v = count - 10'd1;
            default: next_v = count;
        endcase
        return next_v;
    endfunction

    logic [9:0] uni_count_r;
    logic [9:0] gen_count_r;
    logic [9:0] uni_cap_s;
    logic [9:0] gen_cap_s;
    logic [9:0] uni_vac_s;
    logic [9:0] gen_vac_s;
    logic       uni_inc_s;
    logic       uni_dec_s;
    logic       gen_inc_s;
    logic       gen_dec_s;
    logic [9:0] uni_next_s;
    logic [9:0] gen_next_s;

    assign uni_cap_s = uni_cap_f(bus.current_hour);
    assign gen_cap_s = 10'(TOTAL_CAPACITY) - uni_cap_s;
    assign uni_vac_s = vacancy_f(uni_cap_s, uni_count_r);
    assign gen_vac_s = vacancy_f(gen_cap_s, gen_count_r);

    // Decide acceptance of this cycle's entry request from pre-edge vacancy.
    always_comb begin
        uni_inc_s = 1'b0;
        gen_inc_s = 1'b0;
        if (bus.car_entered) begin
            if (bus.is_uni_car_entered) begin
                if (uni_vac_s != 10'd0) begin
                    uni_inc_s = 1'b1;
                end else begin
`ifdef PARKING_UNI_OVERFLOW_EN
                    gen_inc_s = (gen_vac_s != 10'd0);
`else
                    gen_inc_s = 1'b0;
`endif
                end
            end else begin
                gen_inc_s = (gen_vac_s != 10'd0);
            end
        end else begin
            uni_inc_s = 1'b0;
            gen_inc_s = 1'b0;
        end
    end

    // Decide acceptance of this cycle's exit request; counters never underflow.
    always_comb begin
        uni_dec_s = 1'b0;
        gen_dec_s = 1'b0;
        if (bus.car_exited) begin
            if (bus.is_uni_car_exited) begin
                if (uni_count_r != 10'd0) begin
                    uni_dec_s = 1'b1;
                end else begin
`ifdef PARKING_UNI_OVERFLOW_EN
                    gen_dec_s = (gen_count_r != 10'd0);
`else
                    gen_dec_s = 1'b0;
`endif
                end
            end else begin
                gen_dec_s = (gen_count_r != 10'd0);
            end
        end else begin
            uni_dec_s = 1'b0;
            gen_dec_s = 1'b0;
        end
    end

    assign uni_next_s = step_f(uni_count_r, uni_inc_s, uni_dec_s);
    assign gen_next_s = step_f(gen_count_r, gen_inc_s, gen_dec_s);

    // Occupancy counters, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uni_count_r <= 10'd0;
            gen_count_r <= 10'd0;
        end else begin
            uni_count_r <= uni_next_s;
            gen_count_r <= gen_next_s;
        end
    end

    assign bus.uni_parked_car       = uni_count_r;
    assign bus.parked_car           = gen_count_r;
    assign bus.uni_vacated_space    = uni_vac_s;
    assign bus.vacated_space        = gen_vac_s;
    assign bus.uni_is_vacated_space = (uni_vac_s != 10'd0);
    assign bus.is_vacated_space     = (gen_vac_s != 10'd0);

endmodule

// File: tb/tb_parking_management.sv
// ---------------------------------------------------------------------------
// tb_parking_management
// Directed bench for parking_management. A behavioural occupancy model
// (plain integers, capacities from the hour rules) is compared against every
// DUT report on each falling clock edge; literal checks at the key points of
// the scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_parking_management;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    parking_management_if bus_if ();

    parking_management dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Free-running clock, period 10.
    initial begin
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    int m_uni = 0;
    int m_gen = 0;

    // University capacity by the hour-of-day rules.
    function automatic int m_uni_cap(input int h);
        if (h >= 8 && h <= 12)       return 500;
        else if (h >= 13 && h <= 15) return 500 - 50 * (h - 12);
        else                         return 200;
    endfunction

    function automatic int m_gen_cap(input int h);
        return 700 - m_uni_cap(h);
    endfunction

    function automatic int m_vac(input int cap, input int cnt);
        return (cap > cnt) ? cap - cnt : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
        end
    endtask

    // Reference occupancy model: decisions use the pre-edge counts.
    always @(posedge clk or negedge reset) begin : model
        int h, uv, gv, ui, gi, ud, gd;
        if (!reset) begin
            m_uni <= 0;
            m_gen <= 0;
        end else begin
            h  = int'(bus_if.current_hour);
            uv = m_vac(m_uni_cap(h), m_uni);
            gv = m_vac(m_gen_cap(h), m_gen);
            ui = 0; gi = 0; ud = 0; gd = 0;
            if (bus_if.car_entered) begin
                if (bus_if.is_uni_car_entered) begin
                    if (uv > 0) ui = 1;
`ifdef PARKING_UNI_OVERFLOW_EN
                    else if (gv > 0) gi = 1;
`endif
                end else if (gv > 0) gi = 1;
            end
            if (bus_if.car_exited) begin
                if (bus_if.is_uni_car_exited) begin
                    if (m_uni > 0) ud = 1;
`ifdef PARKING_UNI_OVERFLOW_EN
                    else if (m_gen > 0) gd = 1;
`endif
                end else if (m_gen > 0) gd = 1;
            end
            m_uni <= m_uni + ui - ud;
            m_gen <= m_gen + gi - gd;
        end
    end

    // Continuous comparison of every report against the model.
    always @(negedge clk) begin : compare
        int h, uv, gv;
        h  = int'(bus_if.current_hour);
        uv = m_vac(m_uni_cap(h), m_uni);
        gv = m_vac(m_gen_cap(h), m_gen);
        chk("uni_parked_car",       32'(bus_if.uni_parked_car),       32'(m_uni));
        chk("parked_car",           32'(bus_if.parked_car),           32'(m_gen));
        chk("uni_vacated_space",    32'(bus_if.uni_vacated_space),    32'(uv));
        chk("vacated_space",        32'(bus_if.vacated_space),        32'(gv));
        chk("uni_is_vacated_space", 32'(bus_if.uni_is_vacated_space), 32'(uv != 0));
        chk("is_vacated_space",     32'(bus_if.is_vacated_space),     32'(gv != 0));
    end

    task automatic drive(input logic ce, input logic ue, input logic cx, input logic ux);
        bus_if.car_entered        = ce;
        bus_if.is_uni_car_entered = ue;
        bus_if.car_exited         = cx;
        bus_if.is_uni_car_exited  = ux;
    endtask

    // Run n rising edges with the current inputs, ending 1 unit after the last.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        bus_if.current_hour = 5'd0;

        // Reset state at night and in daytime.
        #12;
        chk("rst_uni_parked", 32'(bus_if.uni_parked_car), 32'd0);
        chk("rst_parked",     32'(bus_if.parked_car),     32'd0);
        chk("rst_uni_vac_h0", 32'(bus_if.uni_vacated_space), 32'd200);
        chk("rst_vac_h0",     32'(bus_if.vacated_space),     32'd500);
        bus_if.current_hour = 5'd10;
        #1;
        chk("rst_uni_vac_h10", 32'(bus_if.uni_vacated_space), 32'd500);
        chk("rst_vac_h10",     32'(bus_if.vacated_space),     32'd200);
        chk("rst_flags",       32'({bus_if.uni_is_vacated_space, bus_if.is_vacated_space}), 32'd3);
        bus_if.current_hour = 5'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 120 general cars at night.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(120);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gen120_parked",  32'(bus_if.parked_car),        32'd120);
        chk("gen120_vac",     32'(bus_if.vacated_space),     32'd380);
        chk("gen120_flag",    32'(bus_if.is_vacated_space),  32'd1);
        chk("gen120_uni_vac", 32'(bus_if.uni_vacated_space), 32'd200);

        // Daytime: general section fills, excess ignored.
        bus_if.current_hour = 5'd10;
        #1;
        chk("h10_vac", 32'(bus_if.vacated_space), 32'd80);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(100);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("genfull_parked", 32'(bus_if.parked_car),       32'd200);
        chk("genfull_vac",    32'(bus_if.vacated_space),    32'd0);
        chk("genfull_flag",   32'(bus_if.is_vacated_space), 32'd0);

        // University fill then afternoon capacity shrink.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cycles(450);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("uni450_parked", 32'(bus_if.uni_parked_car),    32'd450);
        chk("uni450_vac",    32'(bus_if.uni_vacated_space), 32'd50);
        bus_if.current_hour = 5'd14;
        #1;
        chk("h14_uni_vac",  32'(bus_if.uni_vacated_space),    32'd0);
        chk("h14_uni_flag", 32'(bus_if.uni_is_vacated_space), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cycles(5);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
`ifndef PARKING_UNI_OVERFLOW_EN
        chk("h14_uni_reject", 32'(bus_if.uni_parked_car), 32'd450);
        chk("h14_gen_same",   32'(bus_if.parked_car),     32'd200);
`endif
        bus_if.current_hour = 5'd16;
        #1;
        chk("h16_uni_vac",  32'(bus_if.uni_vacated_space), 32'd0);
        chk("h16_uni_keep", 32'(bus_if.uni_parked_car),    32'd450);

        // Simultaneous entry and exit.
        bus_if.current_hour = 5'd10;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cycles(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_same_gen", 32'(bus_if.parked_car), 32'd199);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        cycles(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_diff_uni", 32'(bus_if.uni_parked_car), 32'd451);
        chk("sim_diff_gen", 32'(bus_if.parked_car),     32'd198);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_uni", 32'(bus_if.uni_parked_car), 32'd0);
        chk("async_rst_gen", 32'(bus_if.parked_car),     32'd0);
        bus_if.current_hour = 5'd27;
        #1;
        chk("h27_uni_vac", 32'(bus_if.uni_vacated_space), 32'd200);
        chk("h27_vac",     32'(bus_if.vacated_space),     32'd500);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Exits with empty counters never wrap.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        cycles(10);
        chk("uni_no_wrap", 32'(bus_if.uni_parked_car), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        cycles(10);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gen_no_wrap",  32'(bus_if.parked_car),    32'd0);
        chk("empty_vac",    32'(bus_if.vacated_space), 32'd500);

        // Mixed traffic sweeping all hour codes; checked by the model.
        for (int i = 0; i < 1200; i++) begin
            bus_if.current_hour = 5'((i / 12) % 32);
            drive(1'(((i * 5) % 7) != 0), 1'(i % 3 != 0),
                  1'(((i * 3) % 5) == 0), 1'(i % 2 != 0));
            cycles(1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
